// File: rtl/desired_drive_pkg.sv
`default_nettype none
// ============================================================================
// Module      : desired_drive_pkg
// Description : Shared constants and helpers for the assist-current pipeline.
//               Holds the default torque deadband, incline clamp bounds and
//               offsets, cadence offset/threshold and the product-width helper.
// Revision    : 1.0 - initial release
// ============================================================================
package desired_drive_pkg;

    // Default torque deadband subtracted from the averaged crank torque.
    localparam int DEF_TORQUE_MIN  = 'h380;

    // Incline is first clamped to this signed window.
    localparam int INCLINE_MIN     = -512;
    localparam int INCLINE_MAX     = 511;

    // Offset turning the clamped incline into an unsigned assist factor.
    localparam int INCLINE_OFFSET  = 256;
    localparam int INCLINE_FAC_MAX = 511;
    localparam int INCLINE_FAC_W   = 9;

    // Cadence below CAD_MIN produces no assist; above it an offset is added.
    localparam int CAD_OFFSET      = 32;
    localparam int CAD_MIN         = 2;

    // Full-precision width of p_a * p_b.
    function automatic int prod_width(input int tq_w, input int set_w, input int cad_w);
        return tq_w + set_w + INCLINE_FAC_W + cad_w + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/desired_drive_pipe_slew.sv
`default_nettype none
// ============================================================================
// Module      : slew_limiter
// Description : Moves target_curr toward raw_target each clock with separate
//               rise/fall step limits (0 = unlimited). Brake clears to zero.
// Ports       : clk, rst_n       - clock, async active-low reset
//               brake            - synchronous clear of target_curr
//               raw_target       - setpoint to follow
//               target_curr      - slew-limited output (registered)
// Revision    : 1.0 - initial release
// ============================================================================
module slew_limiter #(
    parameter int CUR_W   = 12,
    parameter int SLEW_UP = 32,
    parameter int SLEW_DN = 4095
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             brake,
    input  logic [CUR_W-1:0] raw_target,
    output logic [CUR_W-1:0] target_curr
);

    logic [CUR_W-1:0] w_diff_up;
    logic [CUR_W-1:0] w_diff_dn;
    logic [CUR_W-1:0] w_next;

    assign w_diff_up = raw_target - target_curr;
    assign w_diff_dn = target_curr - raw_target;

    // The step casts below are only taken when the limit is smaller than the
    // difference, so the limit always fits in CUR_W bits there.
    always_comb begin
        w_next = target_curr;
        if (raw_target > target_curr) begin
            if (SLEW_UP == 0 || 32'(w_diff_up) <= SLEW_UP)
                w_next = raw_target;
            else
                w_next = target_curr + CUR_W'(SLEW_UP);
        end else if (raw_target < target_curr) begin
            if (SLEW_DN == 0 || 32'(w_diff_dn) <= SLEW_DN)
                w_next = raw_target;
            else
                w_next = target_curr - CUR_W'(SLEW_DN);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            target_curr <= '0;
        else if (brake)
            target_curr <= '0;
        else
            target_curr <= w_next;
    end

endmodule
`default_nettype wire

// File: rtl/desired_drive_pipe.sv
`default_nettype none
// ============================================================================
// Module      : desired_drive_pipe
// Description : Assist-current computation. Conditions torque/incline/cadence,
//               multiplies through a pipelined path with valid tracking,
//               saturates to CUR_W bits and slew-limits the final target.
// Ports       : clk, rst_n       - clock, async active-low reset
//               in_vld           - input sample valid
//               avg_torque       - unsigned averaged crank torque
//               cadence_vec      - unsigned cadence
//               incline          - signed incline
//               setting          - assist level (0 = off)
//               brake            - sync override, flushes pipe and target
//               raw_target       - saturated pipeline result (held)
//               target_curr      - slew-limited target current
//               out_vld          - one-clock pulse when raw_target updates
//               saturated        - raw_target was clipped
//               at_target        - target_curr equals raw_target
// Revision    : 1.0 - initial release
// ============================================================================
module desired_drive_pipe
    import desired_drive_pkg::*;
#(
    parameter int TQ_W       = 12,
    parameter int CAD_W      = 5,
    parameter int INC_W      = 13,
    parameter int SET_W      = 2,
    parameter int CUR_W      = 12,
    parameter int TORQUE_MIN = DEF_TORQUE_MIN,
    parameter int SHIFT      = 15,
    parameter int SLEW_UP    = 32,
    parameter int SLEW_DN    = 4095
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_vld,
    input  logic [TQ_W-1:0]  avg_torque,
    input  logic [CAD_W-1:0] cadence_vec,
    input  logic [INC_W-1:0] incline,
    input  logic [SET_W-1:0] setting,
    input  logic             brake,
    output logic [CUR_W-1:0] raw_target,
    output logic [CUR_W-1:0] target_curr,
    output logic             out_vld,
    output logic             saturated,
    output logic             at_target
);

    localparam int c_cad_w  = CAD_W + 1;
    localparam int c_pa_w   = TQ_W + SET_W;
    localparam int c_pb_w   = INCLINE_FAC_W + c_cad_w;
    localparam int c_prod_w = prod_width(TQ_W, SET_W, CAD_W);
    localparam logic [c_prod_w-1:0] c_cur_max =
        {{(c_prod_w-CUR_W){1'b0}}, {CUR_W{1'b1}}};

    // ---------------- input conditioning (combinational) ----------------
    logic [TQ_W-1:0]          w_torque_pos;
    logic signed [31:0]       w_inc_sat;
    logic signed [31:0]       w_inc_off;
    logic [INCLINE_FAC_W-1:0] w_inc_fac;
    logic [c_cad_w-1:0]       w_cad_fac;

    always_comb begin
        w_torque_pos = '0;
        if (avg_torque > TQ_W'(TORQUE_MIN))
            w_torque_pos = avg_torque - TQ_W'(TORQUE_MIN);
    end

    always_comb begin
        w_inc_sat = 32'($signed(incline));
        if (w_inc_sat > INCLINE_MAX)
            w_inc_sat = INCLINE_MAX;
        else if (w_inc_sat < INCLINE_MIN)
            w_inc_sat = INCLINE_MIN;
        w_inc_off = w_inc_sat + INCLINE_OFFSET;
        if (w_inc_off < 0)
            w_inc_fac = '0;
        else if (w_inc_off > INCLINE_FAC_MAX)
            w_inc_fac = INCLINE_FAC_W'(INCLINE_FAC_MAX);
        else
            w_inc_fac = w_inc_off[INCLINE_FAC_W-1:0];
    end

    assign w_cad_fac = (cadence_vec >= CAD_W'(CAD_MIN))
                     ? {1'b0, cadence_vec} + c_cad_w'(CAD_OFFSET)
                     : '0;

    // ---------------- pipeline registers ----------------
    logic                     r_s1_vld, r_s2_vld, r_s3_vld;
    logic [TQ_W-1:0]          r_torque_pos;
    logic [SET_W-1:0]         r_setting;
    logic [INCLINE_FAC_W-1:0] r_inc_fac;
    logic [c_cad_w-1:0]       r_cad_fac;
    logic [c_pa_w-1:0]        r_p_a;
    logic [c_pb_w-1:0]        r_p_b;
    logic [c_prod_w-1:0]      r_prod;

    logic [c_prod_w-1:0]      w_prod_hi;
    logic                     w_sat;

    assign w_prod_hi = r_prod >> SHIFT;
    assign w_sat     = (w_prod_hi > c_cur_max);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_vld     <= 1'b0;
            r_s2_vld     <= 1'b0;
            r_s3_vld     <= 1'b0;
            out_vld      <= 1'b0;
            r_torque_pos <= '0;
            r_setting    <= '0;
            r_inc_fac    <= '0;
            r_cad_fac    <= '0;
            r_p_a        <= '0;
            r_p_b        <= '0;
            r_prod       <= '0;
            raw_target   <= '0;
            saturated    <= 1'b0;
        end else begin
            // Brake kills every valid, so in-flight and newly presented
            // samples never reach raw_target.
            r_s1_vld <= in_vld   & ~brake;
            r_s2_vld <= r_s1_vld & ~brake;
            r_s3_vld <= r_s2_vld & ~brake;
            out_vld  <= r_s3_vld & ~brake;

            if (in_vld) begin
                r_torque_pos <= w_torque_pos;
                r_setting    <= setting;
                r_inc_fac    <= w_inc_fac;
                r_cad_fac    <= w_cad_fac;
            end
            if (r_s1_vld) begin
                r_p_a <= c_pa_w'(r_torque_pos) * c_pa_w'(r_setting);
                r_p_b <= c_pb_w'(r_inc_fac) * c_pb_w'(r_cad_fac);
            end
            if (r_s2_vld)
                r_prod <= c_prod_w'(r_p_a) * c_prod_w'(r_p_b);

            if (brake) begin
                raw_target <= '0;
                saturated  <= 1'b0;
            end else if (r_s3_vld) begin
                raw_target <= w_sat ? {CUR_W{1'b1}} : w_prod_hi[CUR_W-1:0];
                saturated  <= w_sat;
            end
        end
    end

    // ---------------- slew limiter ----------------
    slew_limiter #(
        .CUR_W   (CUR_W),
        .SLEW_UP (SLEW_UP),
        .SLEW_DN (SLEW_DN)
    ) u_slew (
        .clk         (clk),
        .rst_n       (rst_n),
        .brake       (brake),
        .raw_target  (raw_target),
        .target_curr (target_curr)
    );

    assign at_target = (target_curr == raw_target);

endmodule
`default_nettype wire
